// File: rtl/reorder_buffer_pkg.sv
// Shared constants and types for the reorder buffer and its query ports.
package reorder_buffer_pkg;

    localparam int ROB_SIZE_WIDTH = 4;
    localparam int ROB_SIZE       = 1 << ROB_SIZE_WIDTH;

    localparam logic [ROB_SIZE_WIDTH-1:0] ROB_PTR_ONE  = ROB_SIZE_WIDTH'(1);
    localparam logic [ROB_SIZE_WIDTH:0]   ROB_CNT_ONE  = (ROB_SIZE_WIDTH + 1)'(1);
    localparam logic [ROB_SIZE_WIDTH:0]   ROB_CNT_FULL = (ROB_SIZE_WIDTH + 1)'(ROB_SIZE);

    typedef enum logic [1:0] {
        ROB_TYPE_REG    = 2'd0,
        ROB_TYPE_STORE  = 2'd1,
        ROB_TYPE_BRANCH = 2'd2,
        ROB_TYPE_EXIT   = 2'd3
    } rob_type_e;

    // One queue slot; value doubles as the actual-taken flag (bit 0) for branches.
    typedef struct packed {
        logic        busy;
        logic        ready;
        rob_type_e   kind;
        logic [4:0]  rd;
        logic        pred;
        logic [31:0] alt_pc;
        logic [31:0] value;
    } rob_entry_t;

endpackage

// File: rtl/rob_query_port.sv
// Combinational operand lookup: RoB id -> {ready, value}, optionally bypassing
// the broadcasts that land on this same cycle (LSB has priority over ALU).
module rob_query_port
    import reorder_buffer_pkg::*;
(
    input  logic [ROB_SIZE_WIDTH-1:0] query_id,
    input  logic [ROB_SIZE-1:0]       busy_vec,
    input  logic [ROB_SIZE-1:0]       ready_vec,
    input  logic [ROB_SIZE*32-1:0]    value_vec,
    input  logic                      rs_byp_valid,
    input  logic [ROB_SIZE_WIDTH-1:0] rs_byp_id,
    input  logic [31:0]               rs_byp_value,
    input  logic                      lsb_byp_valid,
    input  logic [ROB_SIZE_WIDTH-1:0] lsb_byp_id,
    input  logic [31:0]               lsb_byp_value,
    output logic                      query_ready,
    output logic [31:0]               query_value
);

    logic [ROB_SIZE_WIDTH+4:0] bit_base;

    assign bit_base = {query_id, 5'd0};

    // Stored result first, then let a live broadcast to a busy entry override it.
    always_comb begin
        query_ready = busy_vec[query_id] & ready_vec[query_id];
        query_value = value_vec[bit_base +: 32];
        if (busy_vec[query_id]) begin
            if (lsb_byp_valid && (lsb_byp_id == query_id)) begin
                query_ready = 1'b1;
                query_value = lsb_byp_value;
            end else if (rs_byp_valid && (rs_byp_id == query_id)) begin
                query_ready = 1'b1;
                query_value = rs_byp_value;
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement queue. Allocates ids at the tail, captures ALU/LSB
// result broadcasts, answers operand queries and retires one head entry per
// cycle (regfile write, store release, mispredict flush, halt).
// Optional feature: define ROB_BYPASS_EN to let operand queries also see the
// results broadcast on the current cycle.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      issue_valid,
    input  logic [1:0]                issue_type,
    input  logic [4:0]                issue_rd,
    input  logic                      issue_pred,
    input  logic [31:0]               issue_alt_pc,
    input  logic                      issue_ready,
    input  logic [31:0]               issue_value,
    output logic [ROB_SIZE_WIDTH-1:0] tail_id,
    output logic                      full,
    output logic                      empty,
    input  logic                      rs_ready,
    input  logic [ROB_SIZE_WIDTH-1:0] rs_rob_id,
    input  logic [31:0]               rs_value,
    input  logic                      lsb_ready,
    input  logic [ROB_SIZE_WIDTH-1:0] lsb_rob_id,
    input  logic [31:0]               lsb_value,
    input  logic [ROB_SIZE_WIDTH-1:0] query_id1,
    input  logic [ROB_SIZE_WIDTH-1:0] query_id2,
    output logic                      query_ready1,
    output logic [31:0]               query_value1,
    output logic                      query_ready2,
    output logic [31:0]               query_value2,
    output logic                      commit_valid,
    output logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
    output logic [4:0]                commit_rd,
    output logic [31:0]               commit_value,
    output logic                      store_commit,
    output logic [ROB_SIZE_WIDTH-1:0] store_rob_id,
    output logic                      rob_clear,
    output logic [31:0]               redirect_pc,
    output logic                      halt
);

    rob_entry_t                entry_q [ROB_SIZE];
    rob_entry_t                entry_d [ROB_SIZE];
    logic [ROB_SIZE_WIDTH-1:0] head_q, head_d;
    logic [ROB_SIZE_WIDTH-1:0] tail_q, tail_d;
    logic [ROB_SIZE_WIDTH:0]   count_q, count_d;
    logic                      halt_q, halt_d;
    logic                      commit_valid_q, commit_valid_d;
    logic [ROB_SIZE_WIDTH-1:0] commit_rob_id_q, commit_rob_id_d;
    logic [4:0]                commit_rd_q, commit_rd_d;
    logic [31:0]               commit_value_q, commit_value_d;
    logic                      store_commit_q, store_commit_d;
    logic [ROB_SIZE_WIDTH-1:0] store_rob_id_q, store_rob_id_d;
    logic                      rob_clear_q, rob_clear_d;
    logic [31:0]               redirect_pc_q, redirect_pc_d;

    rob_entry_t                head_entry;
    logic                      accept_in;
    logic                      issue_fire;
    logic                      retire_fire;
    logic                      mispredict;

    logic [ROB_SIZE-1:0]       busy_vec;
    logic [ROB_SIZE-1:0]       ready_vec;
    logic [ROB_SIZE*32-1:0]    value_vec;
    logic                      rs_byp_valid;
    logic                      lsb_byp_valid;

    assign full       = (count_q == ROB_CNT_FULL);
    assign empty      = (count_q == '0);
    assign tail_id    = tail_q;
    assign head_entry = entry_q[head_q];
    // The cycle after a flush belongs to the rest of the core restarting; inputs are dropped.
    assign accept_in  = rdy & ~rob_clear_q;

    // Next-state: writebacks, then issue (wins over a same-id writeback), then retire and flush.
    always_comb begin
        entry_d         = entry_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        halt_d          = halt_q;
        commit_valid_d  = 1'b0;
        commit_rob_id_d = commit_rob_id_q;
        commit_rd_d     = commit_rd_q;
        commit_value_d  = commit_value_q;
        store_commit_d  = 1'b0;
        store_rob_id_d  = store_rob_id_q;
        rob_clear_d     = 1'b0;
        redirect_pc_d   = redirect_pc_q;
        issue_fire      = 1'b0;
        retire_fire     = 1'b0;
        mispredict      = 1'b0;

        if (accept_in) begin
            if (rs_ready && entry_q[rs_rob_id].busy) begin
                entry_d[rs_rob_id].ready = 1'b1;
                entry_d[rs_rob_id].value = rs_value;
            end
            if (lsb_ready && entry_q[lsb_rob_id].busy) begin
                entry_d[lsb_rob_id].ready = 1'b1;
                entry_d[lsb_rob_id].value = lsb_value;
            end
            if (issue_valid && !full) begin
                entry_d[tail_q] = '{busy: 1'b1, ready: issue_ready, kind: rob_type_e'(issue_type),
                                   rd: issue_rd, pred: issue_pred, alt_pc: issue_alt_pc,
                                   value: issue_value};
                tail_d     = tail_q + ROB_PTR_ONE;
                issue_fire = 1'b1;
            end
        end

        if (rdy && head_entry.busy && head_entry.ready && !halt_q) begin
            retire_fire            = 1'b1;
            entry_d[head_q].busy   = 1'b0;
            entry_d[head_q].ready  = 1'b0;
            head_d                 = head_q + ROB_PTR_ONE;
            case (head_entry.kind)
                ROB_TYPE_REG: begin
                    commit_valid_d  = 1'b1;
                    commit_rob_id_d = head_q;
                    commit_rd_d     = head_entry.rd;
                    commit_value_d  = head_entry.value;
                end
                ROB_TYPE_STORE: begin
                    store_commit_d = 1'b1;
                    store_rob_id_d = head_q;
                end
                ROB_TYPE_BRANCH: mispredict = (head_entry.value[0] != head_entry.pred);
                ROB_TYPE_EXIT:   halt_d     = 1'b1;
                default: ;
            endcase
        end

        if (issue_fire && !retire_fire) begin
            count_d = count_q + ROB_CNT_ONE;
        end else if (!issue_fire && retire_fire) begin
            count_d = count_q - ROB_CNT_ONE;
        end

        if (mispredict) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entry_d[i].busy  = 1'b0;
                entry_d[i].ready = 1'b0;
            end
            head_d        = '0;
            tail_d        = '0;
            count_d       = '0;
            rob_clear_d   = 1'b1;
            redirect_pc_d = head_entry.alt_pc;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                entry_q[i] <= '0;
            end
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            halt_q          <= 1'b0;
            commit_valid_q  <= 1'b0;
            commit_rob_id_q <= '0;
            commit_rd_q     <= '0;
            commit_value_q  <= '0;
            store_commit_q  <= 1'b0;
            store_rob_id_q  <= '0;
            rob_clear_q     <= 1'b0;
            redirect_pc_q   <= '0;
        end else begin
            entry_q         <= entry_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            halt_q          <= halt_d;
            commit_valid_q  <= commit_valid_d;
            commit_rob_id_q <= commit_rob_id_d;
            commit_rd_q     <= commit_rd_d;
            commit_value_q  <= commit_value_d;
            store_commit_q  <= store_commit_d;
            store_rob_id_q  <= store_rob_id_d;
            rob_clear_q     <= rob_clear_d;
            redirect_pc_q   <= redirect_pc_d;
        end
    end

    assign commit_valid  = commit_valid_q;
    assign commit_rob_id = commit_rob_id_q;
    assign commit_rd     = commit_rd_q;
    assign commit_value  = commit_value_q;
    assign store_commit  = store_commit_q;
    assign store_rob_id  = store_rob_id_q;
    assign rob_clear     = rob_clear_q;
    assign redirect_pc   = redirect_pc_q;
    assign halt          = halt_q;

    // Flatten per-entry status into vectors for the query ports.
    for (genvar gi = 0; gi < ROB_SIZE; gi++) begin : g_flat
        assign busy_vec[gi]            = entry_q[gi].busy;
        assign ready_vec[gi]           = entry_q[gi].ready;
        assign value_vec[gi*32 +: 32]  = entry_q[gi].value;
    end

`ifdef ROB_BYPASS_EN
    assign rs_byp_valid  = rs_ready & ~rob_clear_q;
    assign lsb_byp_valid = lsb_ready & ~rob_clear_q;
`else
    assign rs_byp_valid  = 1'b0;
    assign lsb_byp_valid = 1'b0;
`endif

    rob_query_port u_query1 (
        .query_id      (query_id1),
        .busy_vec      (busy_vec),
        .ready_vec     (ready_vec),
        .value_vec     (value_vec),
        .rs_byp_valid  (rs_byp_valid),
        .rs_byp_id     (rs_rob_id),
        .rs_byp_value  (rs_value),
        .lsb_byp_valid (lsb_byp_valid),
        .lsb_byp_id    (lsb_rob_id),
        .lsb_byp_value (lsb_value),
        .query_ready   (query_ready1),
        .query_value   (query_value1)
    );

    rob_query_port u_query2 (
        .query_id      (query_id2),
        .busy_vec      (busy_vec),
        .ready_vec     (ready_vec),
        .value_vec     (value_vec),
        .rs_byp_valid  (rs_byp_valid),
        .rs_byp_id     (rs_rob_id),
        .rs_byp_value  (rs_value),
        .lsb_byp_valid (lsb_byp_valid),
        .lsb_byp_id    (lsb_rob_id),
        .lsb_byp_value (lsb_value),
        .query_ready   (query_ready2),
        .query_value   (query_value2)
    );

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: a queue-based reference model predicts
// retirements; a negedge monitor pops and compares each visible pulse.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst, rdy, issue_valid, issue_pred, issue_ready;
    logic [1:0]  issue_type;
    logic [4:0]  issue_rd;
    logic [31:0] issue_alt_pc, issue_value;
    logic [3:0]  tail_id;
    logic        full, empty;
    logic        rs_ready, lsb_ready;
    logic [3:0]  rs_rob_id, lsb_rob_id, query_id1, query_id2;
    logic [31:0] rs_value, lsb_value;
    logic        query_ready1, query_ready2;
    logic [31:0] query_value1, query_value2;
    logic        commit_valid, store_commit, rob_clear, halt;
    logic [3:0]  commit_rob_id, store_rob_id;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value, redirect_pc;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
        .issue_pred(issue_pred), .issue_alt_pc(issue_alt_pc), .issue_ready(issue_ready),
        .issue_value(issue_value), .tail_id(tail_id), .full(full), .empty(empty),
        .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value),
        .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value),
        .query_id1(query_id1), .query_id2(query_id2),
        .query_ready1(query_ready1), .query_value1(query_value1),
        .query_ready2(query_ready2), .query_value2(query_value2),
        .commit_valid(commit_valid), .commit_rob_id(commit_rob_id), .commit_rd(commit_rd),
        .commit_value(commit_value), .store_commit(store_commit), .store_rob_id(store_rob_id),
        .rob_clear(rob_clear), .redirect_pc(redirect_pc), .halt(halt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the in-flight instructions in program order.
    typedef struct {
        logic [3:0]  id;
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic        pred;
        logic [31:0] alt;
        logic        rdyb;
        logic [31:0] value;
    } m_ent_t;
    m_ent_t mq[$];
    int     m_tail  = 0;
    bit     m_clear = 0;
    bit     m_halt  = 0;
    bit     m_pulse = 0;

    // Expected visible retire events: 0 = regfile commit, 1 = store release, 2 = flush.
    typedef struct {
        int          ev;
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;
    exp_t expq[$];

    typedef struct {
        bit          r;
        bit          iv;
        logic [1:0]  it;
        logic [4:0]  rd;
        bit          pred;
        logic [31:0] alt;
        bit          irdy;
        logic [31:0] ival;
        bit          rsv;
        logic [3:0]  rsid;
        logic [31:0] rsval;
        bit          lsv;
        logic [3:0]  lsid;
        logic [31:0] lsval;
        logic [3:0]  q1;
        logic [3:0]  q2;
    } stim_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic stim_t idle_stim();
        stim_t s;
        s = '{r: 1'b1, iv: 1'b0, it: 2'd0, rd: 5'd0, pred: 1'b0, alt: 32'd0, irdy: 1'b0,
              ival: 32'd0, rsv: 1'b0, rsid: 4'd0, rsval: 32'd0, lsv: 1'b0, lsid: 4'd0,
              lsval: 32'd0, q1: 4'd0, q2: 4'd0};
        return s;
    endfunction

    // Expected query answer from the model (plus same-cycle broadcast when bypass is built in).
    task automatic q_expect(input logic [3:0] id, input stim_t s, output bit er, output logic [31:0] ev);
        er = 1'b0;
        ev = 32'd0;
        foreach (mq[i]) begin
            if (mq[i].id == id) begin
                if (mq[i].rdyb) begin
                    er = 1'b1;
                    ev = mq[i].value;
                end
`ifdef ROB_BYPASS_EN
                if (!m_clear && s.rsv && s.rsid == id) begin
                    er = 1'b1;
                    ev = s.rsval;
                end
                if (!m_clear && s.lsv && s.lsid == id) begin
                    er = 1'b1;
                    ev = s.lsval;
                end
`endif
            end
        end
    endtask

    // One clock: check state after the last edge, drive inputs, check queries, advance model.
    task automatic step(input stim_t s);
        bit          ret;
        bit          nc;
        bit          er;
        logic [31:0] ev;
        m_ent_t      h;
        m_ent_t      n;
        @(posedge clk);
        #1;
        chk("pulse_timing", 32'(commit_valid | store_commit | rob_clear), 32'(m_pulse));
        chk("full", 32'(full), 32'(mq.size() == 16));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("tail_id", 32'(tail_id), 32'(m_tail));
        chk("halt", 32'(halt), 32'(m_halt));
        rdy = s.r; issue_valid = s.iv; issue_type = s.it; issue_rd = s.rd;
        issue_pred = s.pred; issue_alt_pc = s.alt; issue_ready = s.irdy; issue_value = s.ival;
        rs_ready = s.rsv; rs_rob_id = s.rsid; rs_value = s.rsval;
        lsb_ready = s.lsv; lsb_rob_id = s.lsid; lsb_value = s.lsval;
        query_id1 = s.q1; query_id2 = s.q2;
        #1;
        q_expect(s.q1, s, er, ev);
        chk("query_ready1", 32'(query_ready1), 32'(er));
        if (er) chk("query_value1", query_value1, ev);
        q_expect(s.q2, s, er, ev);
        chk("query_ready2", 32'(query_ready2), 32'(er));
        if (er) chk("query_value2", query_value2, ev);

        m_pulse = 1'b0;
        nc      = 1'b0;
        if (s.r) begin
            ret = (mq.size() > 0) && mq[0].rdyb && !m_halt;
            if (ret) h = mq[0];
            if (!m_clear) begin
                if (s.rsv) foreach (mq[i]) if (mq[i].id == s.rsid) begin mq[i].rdyb = 1'b1; mq[i].value = s.rsval; end
                if (s.lsv) foreach (mq[i]) if (mq[i].id == s.lsid) begin mq[i].rdyb = 1'b1; mq[i].value = s.lsval; end
                if (s.iv && mq.size() < 16) begin
                    n = '{id: 4'(m_tail), kind: s.it, rd: s.rd, pred: s.pred, alt: s.alt,
                          rdyb: s.irdy, value: s.ival};
                    mq.push_back(n);
                    m_tail = (m_tail + 1) % 16;
                end
            end
            if (ret) begin
                mq.delete(0);
                if (h.kind == 2'd0) begin
                    expq.push_back('{ev: 0, id: h.id, rd: h.rd, data: h.value});
                    m_pulse = 1'b1;
                end else if (h.kind == 2'd1) begin
                    expq.push_back('{ev: 1, id: h.id, rd: 5'd0, data: 32'd0});
                    m_pulse = 1'b1;
                end else if (h.kind == 2'd2) begin
                    if (h.value[0] != h.pred) begin
                        expq.push_back('{ev: 2, id: h.id, rd: 5'd0, data: h.alt});
                        mq.delete();
                        m_tail  = 0;
                        m_pulse = 1'b1;
                        nc      = 1'b1;
                    end
                end else begin
                    m_halt = 1'b1;
                end
            end
        end
        m_clear = nc;
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        int    k;
        s      = idle_stim();
        s.r    = ($urandom_range(0, 9) != 0);
        s.iv   = (mq.size() < 16) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
        s.it   = 2'($urandom_range(0, 2));
        s.rd   = 5'($urandom_range(0, 31));
        s.pred = 1'($urandom_range(0, 1));
        s.alt  = $urandom;
        s.irdy = ($urandom_range(0, 3) == 0);
        s.ival = $urandom;
        if (mq.size() > 0 && $urandom_range(0, 1) == 1) begin
            k       = $urandom_range(0, mq.size() - 1);
            s.rsv   = 1'b1;
            s.rsid  = mq[k].id;
            s.rsval = (mq[k].kind == 2'd2) ? 32'($urandom_range(0, 1)) : $urandom;
        end else if ($urandom_range(0, 7) == 0) begin
            s.rsv   = 1'b1;
            s.rsid  = 4'(m_tail);
            s.rsval = $urandom;
        end
        if (mq.size() > 0 && $urandom_range(0, 2) == 0) begin
            k       = $urandom_range(0, mq.size() - 1);
            s.lsv   = 1'b1;
            s.lsid  = mq[k].id;
            s.lsval = (mq[k].kind == 2'd2) ? 32'($urandom_range(0, 1)) : $urandom;
        end
        s.q1 = (s.rsv && $urandom_range(0, 1) == 1) ? s.rsid : 4'($urandom_range(0, 15));
        s.q2 = (s.lsv && $urandom_range(0, 1) == 1) ? s.lsid : 4'($urandom_range(0, 15));
        return s;
    endfunction

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b0; issue_valid = 1'b0; issue_type = 2'd0; issue_rd = 5'd0;
        issue_pred = 1'b0; issue_alt_pc = 32'd0; issue_ready = 1'b0; issue_value = 32'd0;
        rs_ready = 1'b0; rs_rob_id = 4'd0; rs_value = 32'd0;
        lsb_ready = 1'b0; lsb_rob_id = 4'd0; lsb_value = 32'd0;
        query_id1 = 4'd0; query_id2 = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_tail_id", 32'(tail_id), 32'd0);
        chk("rst_pulses", 32'({commit_valid, store_commit, rob_clear, halt}), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_commit_value", commit_value, 32'd0);
        chk("rst_query_ready", 32'({query_ready1, query_ready2}), 32'd0);
        rst = 1'b0;
        mq.delete(); expq.delete();
        m_tail = 0; m_clear = 1'b0; m_halt = 1'b0; m_pulse = 1'b0;
    endtask

    // Broadcast outstanding results (branches resolve as predicted) until everything retires.
    task automatic drain();
        stim_t s;
        int    n;
        n = 0;
        while ((mq.size() > 0 || expq.size() > 0) && n < 300) begin
            s = idle_stim();
            for (int i = 0; i < mq.size(); i++) begin
                if (!mq[i].rdyb) begin
                    s.rsv   = 1'b1;
                    s.rsid  = mq[i].id;
                    s.rsval = (mq[i].kind == 2'd2) ? 32'(mq[i].pred) : $urandom;
                    break;
                end
            end
            step(s);
            n++;
        end
        chk("drain_bound", 32'(mq.size() + expq.size()), 32'd0);
    endtask

    // Monitor: every visible retire pulse is matched against the oldest expected event.
    exp_t mon_e;
    int   mon_ev;
    always @(negedge clk) begin
        if (!rst && (commit_valid || store_commit || rob_clear)) begin
            mon_ev = commit_valid ? 0 : (store_commit ? 1 : 2);
            if (expq.size() == 0) begin
                chk("unexpected_retire", 32'(mon_ev), 32'hFFFF_FFFF);
            end else begin
                mon_e = expq.pop_front();
                chk("retire_kind", 32'(mon_ev), 32'(mon_e.ev));
                if (mon_e.ev == 0) begin
                    chk("commit_rob_id", 32'(commit_rob_id), 32'(mon_e.id));
                    chk("commit_rd", 32'(commit_rd), 32'(mon_e.rd));
                    chk("commit_value", commit_value, mon_e.data);
                end else if (mon_e.ev == 1) begin
                    chk("store_rob_id", 32'(store_rob_id), 32'(mon_e.id));
                end else begin
                    chk("redirect_pc", redirect_pc, mon_e.data);
                end
                $display("retire kind=%0d id=%0d rd=%0d value=0x%0h pc=0x%0h",
                         mon_ev, commit_valid ? commit_rob_id : store_rob_id,
                         commit_rd, commit_value, redirect_pc);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got no end, expected end");
        $fatal(1);
    end

    initial begin
        stim_t s;
        logic [3:0] id;

        // Single REG result round trip.
        do_reset();
        s = idle_stim(); s.iv = 1'b1; s.it = 2'd0; s.rd = 5'd5; step(s);
        s = idle_stim(); s.rsv = 1'b1; s.rsid = 4'd0; s.rsval = 32'h1234; step(s);
        drain();

        // Fill to full, retire one, next id wraps back to 0; issue while full is dropped.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            s = idle_stim(); s.iv = 1'b1; s.rd = 5'(i); s.ival = 32'(i); step(s);
        end
        s = idle_stim(); s.iv = 1'b1; s.rd = 5'd31; s.irdy = 1'b1;
        s.rsv = 1'b1; s.rsid = 4'd0; s.rsval = 32'hA0; step(s);
        s = idle_stim(); step(s);
        s = idle_stim(); s.iv = 1'b1; s.rd = 5'd7; step(s);
        drain();

        // Mispredicted branch flushes; an issue during the flush cycle is ignored.
        do_reset();
        s = idle_stim(); s.iv = 1'b1; s.it = 2'd2; s.pred = 1'b0; s.alt = 32'h100; step(s);
        s = idle_stim(); s.iv = 1'b1; s.rd = 5'd3; step(s);
        s = idle_stim(); s.rsv = 1'b1; s.rsid = 4'd0; s.rsval = 32'd1; step(s);
        s = idle_stim(); step(s);
        s = idle_stim(); s.iv = 1'b1; s.rd = 5'd9; s.irdy = 1'b1; step(s);
        drain();

        // Out-of-order results retire in order; bypass query on the broadcast cycle.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            s = idle_stim(); s.iv = 1'b1; s.rd = 5'(i + 1); step(s);
        end
        s = idle_stim(); s.rsv = 1'b1; s.rsid = 4'd3; s.rsval = 32'd7; s.q1 = 4'd3; step(s);
        for (int i = 2; i >= 0; i--) begin
            s = idle_stim(); s.rsv = 1'b1; s.rsid = 4'(i); s.rsval = 32'h100 + 32'(i); s.q2 = 4'(i); step(s);
        end
        drain();

        // Store release held off while rdy is low.
        do_reset();
        s = idle_stim(); s.iv = 1'b1; s.it = 2'd1; step(s);
        s = idle_stim(); s.lsv = 1'b1; s.lsid = 4'd0; s.lsval = 32'h55; step(s);
        for (int i = 0; i < 3; i++) begin
            s = idle_stim(); s.r = 1'b0; step(s);
        end
        s = idle_stim(); step(s);
        drain();

        // Randomized traffic, then a mid-run reset.
        for (int i = 0; i < 1500; i++) begin
            step(rand_stim());
        end
        drain();
        for (int i = 0; i < 20; i++) begin
            step(rand_stim());
        end
        do_reset();

        // EXIT retires and halts; later ready entries stay put.
        id = 4'd0;
        s = idle_stim(); s.iv = 1'b1; s.it = 2'd3; s.irdy = 1'b1; step(s);
        s = idle_stim(); s.iv = 1'b1; s.rd = 5'd4; s.irdy = 1'b1; s.ival = 32'h77; s.q1 = id; step(s);
        for (int i = 0; i < 6; i++) begin
            s = idle_stim(); step(s);
        end
        chk("halt_no_retire", 32'(expq.size()), 32'd0);
        do_reset();
        s = idle_stim(); step(s);

        chk("final_queue", 32'(expq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
